// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline control handshake bundle between the core stages and pipe_ctrl
//
// master: the pipeline datapath (drives stall requests and the ID branch decision)
// slave : pipe_ctrl (drives the stall vector, IF/ID flush and PC redirect)
//   stallreq_if/id/ex/mem : per-stage stall requests
//   br, br_addr           : taken branch/jump resolved in ID and its target
//   stall[5:0]            : per-register hold vector, [0]=PC ... [5]=WB (reserved)
//   flush_if              : IF/ID register loads a bubble this cycle
//   redirect, new_pc      : PC loads new_pc this cycle
//   stall_timeout         : sticky runaway-stall flag

interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        br;
    logic [31:0] br_addr;
    logic [5:0]  stall;
    logic        flush_if;
    logic        redirect;
    logic [31:0] new_pc;
    logic        stall_timeout;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, br, br_addr,
        input  stall, flush_if, redirect, new_pc, stall_timeout
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, br, br_addr,
        output stall, flush_if, redirect, new_pc, stall_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall merge, branch redirect sequencing and runaway-stall watchdog for the 5-stage core
//
// Ports:
//   clk                : clock, all state on rising edge
//   rst                : synchronous active-high reset
//   bus (slave)        : pipe_ctrl_if handshake bundle (stall requests, branch, stall vector, redirect)
//   perf_stall_cycles  : cycles with any stall bit set (only with PIPE_CTRL_PERF_EN)
//   perf_redirects     : cycles with redirect asserted (only with PIPE_CTRL_PERF_EN)
// Parameters:
//   STALL_LIMIT        : consecutive-stall count at which stall_timeout sets
//   CNT_W              : width of the consecutive-stall counter
// Optional feature macro: PIPE_CTRL_PERF_EN

module pipe_ctrl #(
    parameter int STALL_LIMIT = 1023,
    parameter int CNT_W       = 10
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_redirects
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STALL_LIMIT);

    state_t            state_q, state_d;
    logic [31:0]       pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    logic [5:0]        stall_c;
    logic              flush_c;
    logic              redirect_c;
    logic [31:0]       new_pc_c;
    logic              any_req;
    logic              back_stall;

    // Stages behind IF stalling keep ID frozen, so a branch seen in ID
    // will be presented again and must not be acted on yet.
    assign back_stall = bus.stallreq_id | bus.stallreq_ex | bus.stallreq_mem;
    assign any_req    = back_stall | bus.stallreq_if;

    always_comb begin
        state_d    = state_q;
        pend_pc_d  = pend_pc_q;
        flush_c    = 1'b0;
        redirect_c = 1'b0;
        new_pc_c   = 32'd0;

        // The deepest stalling stage wins; it holds every register up to
        // and including its own.
        if (bus.stallreq_mem) begin
            stall_c = 6'b011111;
        end else if (bus.stallreq_ex) begin
            stall_c = 6'b001111;
        end else if (bus.stallreq_id) begin
            stall_c = 6'b000111;
        end else if (bus.stallreq_if) begin
            stall_c = 6'b000011;
        end else begin
            stall_c = 6'b000000;
        end

        case (state_q)
            IDLE: begin
                if (bus.br && !back_stall) begin
                    flush_c = 1'b1;
                    if (!bus.stallreq_if) begin
                        redirect_c = 1'b1;
                        new_pc_c   = bus.br_addr;
                    end else begin
                        // Fetch is busy: park the target until it can be taken.
                        pend_pc_d = bus.br_addr;
                        state_d   = PEND;
                    end
                end
            end
            PEND: begin
                // ID only holds bubbles here, so br carries no information.
                flush_c = 1'b1;
                if (!bus.stallreq_if && !bus.stallreq_ex && !bus.stallreq_mem) begin
                    redirect_c = 1'b1;
                    new_pc_c   = pend_pc_q;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The PC must be free to load the redirect target.
        if (redirect_c) begin
            stall_c[0] = 1'b0;
        end

        if (rst) begin
            stall_c    = 6'b000000;
            flush_c    = 1'b0;
            redirect_c = 1'b0;
            new_pc_c   = 32'd0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!any_req) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        timeout_d = timeout_q | (cnt_q == CNT_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pend_pc_q <= 32'd0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.stall         = stall_c;
    assign bus.flush_if      = flush_c;
    assign bus.redirect      = redirect_c;
    assign bus.new_pc        = new_pc_c;
    assign bus.stall_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_redir_q, perf_redir_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_redir_d = perf_redir_q;
        if (stall_c != 6'b000000) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (redirect_c) begin
            perf_redir_d = perf_redir_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_redir_q <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_redir_q <= perf_redir_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_redirects    = perf_redir_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl with a cycle model and directed vectors

module tb_pipe_ctrl;

    localparam int LIMIT = 4;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_ctrl_if bus();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_redirects;
`endif

    pipe_ctrl #(.STALL_LIMIT(LIMIT), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_redirects    (perf_redirects)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: pending redirect flag/target, length of the current
    // stall run (unbounded integer), sticky timeout.
    bit          m_valid = 1'b0;
    bit          m_pend;
    logic [31:0] m_pc;
    int          m_run;
    bit          m_to;

    function automatic void model(input bit pend, input logic [31:0] ppc,
                                  output logic [5:0] st, output logic fl, output logic rd,
                                  output logic [31:0] np, output bit pend_n,
                                  output logic [31:0] ppc_n);
        int deepest;
        bit back;
        deepest = 0;
        if (bus.stallreq_if)  deepest = 1;
        if (bus.stallreq_id)  deepest = 2;
        if (bus.stallreq_ex)  deepest = 3;
        if (bus.stallreq_mem) deepest = 4;
        // Registers 0..deepest are held: a mask of deepest+1 low ones.
        st = (deepest == 0) ? 6'd0 : 6'((1 << (deepest + 1)) - 1);
        back   = bus.stallreq_id || bus.stallreq_ex || bus.stallreq_mem;
        fl     = 1'b0;
        rd     = 1'b0;
        np     = 32'd0;
        pend_n = pend;
        ppc_n  = ppc;
        if (pend) begin
            fl = 1'b1;
            if (!bus.stallreq_if && !bus.stallreq_ex && !bus.stallreq_mem) begin
                rd = 1'b1;
                np = ppc;
                pend_n = 1'b0;
            end
        end else if (bus.br && !back) begin
            fl = 1'b1;
            if (bus.stallreq_if) begin
                pend_n = 1'b1;
                ppc_n  = bus.br_addr;
            end else begin
                rd = 1'b1;
                np = bus.br_addr;
            end
        end
        if (rd) st[0] = 1'b0;
    endfunction

    always @(posedge clk) begin
        logic [5:0]  st;
        logic        fl, rd;
        logic [31:0] np, ppc_n;
        bit          pend_n;
        if (rst) begin
            m_valid <= 1'b1;
            m_pend  <= 1'b0;
            m_pc    <= 32'd0;
            m_run   <= 0;
            m_to    <= 1'b0;
        end else begin
            model(m_pend, m_pc, st, fl, rd, np, pend_n, ppc_n);
            m_pend <= pend_n;
            m_pc   <= ppc_n;
            m_to   <= m_to || (m_run >= LIMIT);
            m_run  <= (bus.stallreq_if || bus.stallreq_id || bus.stallreq_ex || bus.stallreq_mem)
                      ? m_run + 1 : 0;
        end
    end

    always @(negedge clk) begin
        logic [5:0]  st;
        logic        fl, rd;
        logic [31:0] np, ppc_n;
        bit          pend_n;
        if (rst) begin
            chk("m_rst_stall",    32'(bus.stall),    32'd0);
            chk("m_rst_redirect", 32'(bus.redirect), 32'd0);
            chk("m_rst_flush",    32'(bus.flush_if), 32'd0);
            chk("m_rst_new_pc",   bus.new_pc,        32'd0);
        end else if (m_valid) begin
            model(m_pend, m_pc, st, fl, rd, np, pend_n, ppc_n);
            chk("m_stall",    32'(bus.stall),         32'(st));
            chk("m_flush",    32'(bus.flush_if),      32'(fl));
            chk("m_redirect", 32'(bus.redirect),      32'(rd));
            chk("m_new_pc",   bus.new_pc,             np);
            chk("m_timeout",  32'(bus.stall_timeout), 32'(m_to));
        end
    end

    task automatic drive(input logic i, input logic d, input logic e, input logic m,
                         input logic b, input logic [31:0] a);
        bus.stallreq_if  = i;
        bus.stallreq_id  = d;
        bus.stallreq_ex  = e;
        bus.stallreq_mem = m;
        bus.br           = b;
        bus.br_addr      = a;
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 1, 0, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_stall_zero", 32'(bus.stall), 32'd0);
        nxt();
        nxt();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 32'd0);
        @(negedge clk);
        chk("post_rst_timeout",  32'(bus.stall_timeout), 32'd0);
        chk("post_rst_redirect", 32'(bus.redirect),      32'd0);
        chk("post_rst_flush",    32'(bus.flush_if),      32'd0);
        nxt();

        // Stall priority
        drive(0, 1, 0, 1, 0, 32'd0); @(negedge clk); chk("stall_mem_id", 32'(bus.stall), 32'h1f); nxt();
        drive(0, 0, 1, 0, 0, 32'd0); @(negedge clk); chk("stall_ex",     32'(bus.stall), 32'h0f); nxt();
        drive(0, 0, 0, 0, 0, 32'd0); @(negedge clk); chk("stall_none",   32'(bus.stall), 32'h00); nxt();
        drive(1, 0, 0, 0, 0, 32'd0); @(negedge clk); chk("stall_if",     32'(bus.stall), 32'h03); nxt();
        drive(0, 0, 0, 0, 0, 32'd0); nxt();

        // Immediate redirect
        drive(0, 0, 0, 0, 1, 32'h100);
        @(negedge clk);
        chk("br_redirect", 32'(bus.redirect), 32'd1);
        chk("br_new_pc",   bus.new_pc,        32'h100);
        chk("br_flush",    32'(bus.flush_if), 32'd1);
        chk("br_stall",    32'(bus.stall),    32'd0);
        nxt();
        drive(0, 0, 0, 0, 0, 32'd0);
        @(negedge clk);
        chk("idle_new_pc", bus.new_pc, 32'd0);
        nxt();

        // Redirect held while fetch busy
        drive(1, 0, 0, 0, 1, 32'h200);
        @(negedge clk);
        chk("pend0_flush", 32'(bus.flush_if), 32'd1);
        chk("pend0_redir", 32'(bus.redirect), 32'd0);
        nxt();
        for (int k = 1; k < 3; k++) begin
            drive(1, 0, 0, 0, 1, 32'h999);
            @(negedge clk);
            chk("pend_flush", 32'(bus.flush_if), 32'd1);
            chk("pend_redir", 32'(bus.redirect), 32'd0);
            nxt();
        end
        drive(0, 0, 0, 0, 0, 32'd0);
        @(negedge clk);
        chk("pend_exit_redir", 32'(bus.redirect), 32'd1);
        chk("pend_exit_pc",    bus.new_pc,        32'h200);
        chk("pend_exit_stall", 32'(bus.stall),    32'd0);
        nxt();
        @(negedge clk);
        chk("idle_again_flush", 32'(bus.flush_if), 32'd0);
        nxt();

        // Branch ignored while ID holds
        drive(0, 1, 0, 0, 1, 32'h300);
        @(negedge clk);
        chk("br_id_hold_redir", 32'(bus.redirect), 32'd0);
        chk("br_id_hold_flush", 32'(bus.flush_if), 32'd0);
        nxt();
        drive(0, 0, 0, 0, 1, 32'h300);
        @(negedge clk);
        chk("br_retry_pc", bus.new_pc, 32'h300);
        nxt();

        // PEND exit blocked by mem
        drive(1, 0, 0, 0, 1, 32'h400); nxt();
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 1, 0, 32'd0);
            @(negedge clk);
            chk("pend_mem_redir", 32'(bus.redirect), 32'd0);
            chk("pend_mem_stall", 32'(bus.stall),    32'h1f);
            nxt();
        end
        drive(0, 0, 0, 0, 0, 32'd0);
        @(negedge clk);
        chk("pend_mem_exit_pc", bus.new_pc, 32'h400);
        nxt();
        nxt();

        // Watchdog: a 3-cycle run stays below the limit
        for (int k = 0; k < 3; k++) begin drive(0, 0, 1, 0, 0, 32'd0); nxt(); end
        drive(0, 0, 0, 0, 0, 32'd0);
        @(negedge clk); chk("to_short_run", 32'(bus.stall_timeout), 32'd0); nxt();
        @(negedge clk); chk("to_short_run2", 32'(bus.stall_timeout), 32'd0); nxt();
        for (int k = 1; k <= 6; k++) begin
            drive(0, 0, 1, 0, 0, 32'd0);
            @(negedge clk);
            chk("to_long_run", 32'(bus.stall_timeout), (k == 6) ? 32'd1 : 32'd0);
            nxt();
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 0, 0, 32'd0);
            @(negedge clk); chk("to_sticky", 32'(bus.stall_timeout), 32'd1); nxt();
        end
        for (int k = 0; k < 10; k++) begin drive(0, 0, 1, 0, 0, 32'd0); nxt(); end
        drive(0, 0, 0, 0, 0, 32'd0); nxt();

        // Reset while pending
        drive(1, 0, 0, 0, 1, 32'h500); nxt();
        drive(1, 0, 0, 0, 0, 32'd0);
        @(negedge clk); chk("pend_before_rst", 32'(bus.flush_if), 32'd1); nxt();
        rst = 1'b1;
        @(negedge clk); chk("rst_mid_redir", 32'(bus.redirect), 32'd0); nxt();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 32'd0);
        @(negedge clk);
        chk("rst_pend_redir",   32'(bus.redirect),      32'd0);
        chk("rst_pend_flush",   32'(bus.flush_if),      32'd0);
        chk("rst_pend_timeout", 32'(bus.stall_timeout), 32'd0);
        nxt();
        drive(0, 0, 0, 0, 1, 32'h600);
        @(negedge clk);
        chk("rst_then_br_redir", 32'(bus.redirect), 32'd1);
        chk("rst_then_br_pc",    bus.new_pc,        32'h600);
        nxt();
        drive(0, 1, 0, 0, 0, 32'd0); nxt();
        drive(0, 1, 0, 0, 0, 32'd0); nxt();
        drive(0, 0, 0, 0, 0, 32'd0); nxt();
        drive(0, 0, 1, 0, 0, 32'd0); nxt();
        drive(0, 0, 1, 0, 0, 32'd0); nxt();
        drive(0, 0, 0, 0, 0, 32'd0); nxt();
        drive(0, 0, 0, 1, 0, 32'd0); nxt();
        drive(0, 0, 0, 0, 0, 32'd0); nxt();
        drive(0, 0, 0, 0, 1, 32'h700); nxt();
        drive(0, 0, 0, 0, 0, 32'd0);
        @(negedge clk);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_redirects",    perf_redirects,    32'd2);
        chk("perf_stall_cycles", perf_stall_cycles, 32'd5);
`endif
        chk("final_timeout", 32'(bus.stall_timeout), 32'd0);
        nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the 5-stage RV32I core (IF, ID, EX, MEM, WB). It merges stall requests from IF, ID, EX and MEM into one stall vector, sequences the PC redirect for branches/jumps resolved in ID, and holds a redirect pending while instruction fetch is busy. It also watches for runaway stalls and raises a sticky timeout flag.

Parameters:
STALL_LIMIT, 1023, consecutive-stall cycle count at which stall_timeout sets
CNT_W, 10, width of the consecutive-stall counter; STALL_LIMIT <= 2^CNT_W-1

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
stallreq_if  input  1  instruction fetch busy
stallreq_id  input  1  ID load-use stall
stallreq_ex  input  1  EX multi-cycle busy
stallreq_mem  input  1  data memory busy
br  input  1  ID taken branch/jump (combinational from ID)
br_addr  input  32  target for br
stall  output  6  stall[0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB, [5]=WB (reserved, always 0)
flush_if  output  1  IF/ID register loads a bubble (NOP) this cycle
redirect  output  1  PC loads new_pc this cycle
new_pc  output  32  redirect target
stall_timeout  output  1  sticky runaway-stall flag

Behaviour:
- Stall priority: mem > ex > id > if. Source at stage k holds all registers up to and including stage k; the register after k loads a bubble. mem: stall=6'b011111; ex: 6'b001111; id: 6'b000111; if: 6'b000011; none: 0. stall is combinational, same cycle as the requests.
- FSM states: IDLE, PEND. pend_pc is a 32-bit register.
- IDLE, br=1, stallreq_id/ex/mem=0, stallreq_if=0: redirect=1, new_pc=br_addr, flush_if=1, stall[0]=0 (PC loads target). Stay in IDLE.
- IDLE, br=1, stallreq_id/ex/mem=0, stallreq_if=1: latch pend_pc<=br_addr and go to PEND. flush_if=1, redirect=0.
- IDLE, br=1 with any of id/ex/mem stall: ignored. ID holds, so br is presented again next cycle.
- PEND: flush_if=1 every cycle and br is ignored, because ID only sees bubbles.
- PEND exit: when stallreq_if=0 and stallreq_ex=0 and stallreq_mem=0, drive redirect=1, new_pc=pend_pc, stall[0]=0, and go to IDLE.
- PEND with stallreq_if=0 but ex/mem busy: remain in PEND.
- new_pc=0 whenever redirect=0.
- Stall counter: increments each cycle any stallreq_* is high and saturates at 2^CNT_W-1. It clears to 0 on any cycle with no stallreq_*.
- stall_timeout: when the counter equals STALL_LIMIT, stall_timeout<=1. It stays at 1 until rst.
- Reset, including mid-PEND: state=IDLE, pend_pc=0, counter=0, stall_timeout=0, redirect=0, flush_if=0, new_pc=0. While rst=1, stall=0.

Optional Feature:
PIPE_CTRL_PERF_EN: when defined, adds outputs perf_stall_cycles[31:0] and perf_redirects[31:0].
- perf_stall_cycles increments each cycle stall!=0.
- perf_redirects increments each cycle redirect=1.
- Both counters are free-running, wrap at 2^32, and clear on rst.
When undefined, neither port nor counter exists and all other behaviour is unchanged.

Test Plan:
1. stallreq_mem=1 and stallreq_id=1 in the same cycle -> stall=6'b011111. stallreq_ex alone -> 6'b001111. All requests low -> 6'b000000.
2. IDLE, br=1, br_addr=32'h0000_0100, no stalls -> same cycle redirect=1, new_pc=32'h100, flush_if=1, stall[0]=0.
3. br=1, br_addr=32'h0000_0200, stallreq_if=1 held 3 cycles -> PEND entered, flush_if=1 for 3 cycles, redirect=0. On the cycle stallreq_if drops: redirect=1, new_pc=32'h200, then back to IDLE.
4. In PEND, stallreq_if=0 while stallreq_mem=1 for 2 cycles -> redirect stays 0. Redirect to pend_pc fires the cycle stallreq_mem drops.
5. STALL_LIMIT=4, stallreq_ex held 6 cycles -> stall_timeout rises after the 4th-count edge and stays 1 after stallreq_ex drops. A 3-cycle stall after reset never sets it.
6. rst pulsed while in PEND -> next cycle redirect=0, flush_if=0, stall_timeout=0. A subsequent br with no stalls redirects immediately. With PIPE_CTRL_PERF_EN: 2 redirects and 5 stall cycles read perf_redirects=2, perf_stall_cycles=5.
